// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    typedef enum logic [1:0] {
        OwnNone,
        OwnIfetch,
        OwnData
    } owner_e;

    localparam logic [3:0] FULL_MASK = 4'hF;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant decision between fetch and data requesters, with a data-streak limit so a
// pending fetch cannot be starved by back-to-back data traffic.
module mem_arb_grant #(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic ireq_valid,
    input  logic dreq_valid,
    input  logic in_idle,
    output logic grant_i,
    output logic grant_d
);

    localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);

    logic [SW-1:0] streak_q, streak_d;
    logic          at_limit;

    assign at_limit = (streak_q == SW'(MAX_D_STREAK));

    always_comb begin
        grant_d = in_idle & dreq_valid & ~(ireq_valid & at_limit);
        grant_i = in_idle & ireq_valid & ~grant_d;
    end

    // Streak only counts data wins over a waiting fetch.
    always_comb begin
        streak_d = streak_q;
        if (!ireq_valid || grant_i) begin
            streak_d = '0;
        end else if (grant_d && !at_limit) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory port between fetch and data requesters,
// one transaction outstanding at a time.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ireq_valid,
    input  logic [31:0] i_ireq_addr,
    output logic        o_ireq_ready,
    output logic        o_iresp_valid,
    output logic [31:0] o_iresp_rdata,
    input  logic        i_dreq_valid,
    input  logic [31:0] i_dreq_addr,
    input  logic        i_dreq_wen,
    input  logic [31:0] i_dreq_wdata,
    input  logic [3:0]  i_dreq_mask,
    output logic        o_dreq_ready,
    output logic        o_dresp_valid,
    output logic [31:0] o_dresp_rdata,
    output logic        o_mem_req_valid,
    input  logic        i_mem_req_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_resp_valid,
    input  logic [31:0] i_mem_resp_rdata
);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [29:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;

    logic in_idle, in_issue, in_wait;
    logic grant_i, grant_d;
    logic iresp_valid, dresp_valid;

    // Byte offsets are dropped: the memory port is word-addressed.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{i_ireq_addr[1:0], i_dreq_addr[1:0]};

    assign in_idle  = (state_q == StIdle);
    assign in_issue = (state_q == StIssue);
    assign in_wait  = (state_q == StWait);

    mem_arb_grant #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_grant (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .ireq_valid (i_ireq_valid),
        .dreq_valid (i_dreq_valid),
        .in_idle    (in_idle),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        unique case (state_q)
            StIdle: begin
                if (grant_d) begin
                    state_d = StIssue;
                    owner_d = OwnData;
                    addr_d  = i_dreq_addr[31:2];
                    wen_d   = i_dreq_wen;
                    wdata_d = i_dreq_wdata;
                    mask_d  = i_dreq_mask;
                end else if (grant_i) begin
                    state_d = StIssue;
                    owner_d = OwnIfetch;
                    addr_d  = i_ireq_addr[31:2];
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    mask_d  = FULL_MASK;
                end
            end
            StIssue: begin
                if (i_mem_req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (i_mem_resp_valid) begin
                    state_d = StIdle;
                    owner_d = OwnNone;
                end
            end
            default: begin
                state_d = StIdle;
                owner_d = OwnNone;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            owner_q <= OwnNone;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
        end
    end

    // Responses route straight through to the owner; stray responses are dropped.
    always_comb begin
        iresp_valid     = in_wait & i_mem_resp_valid & (owner_q == OwnIfetch);
        dresp_valid     = in_wait & i_mem_resp_valid & (owner_q == OwnData);
        o_ireq_ready    = grant_i;
        o_dreq_ready    = grant_d;
        o_iresp_valid   = iresp_valid;
        o_iresp_rdata   = iresp_valid ? i_mem_resp_rdata : '0;
        o_dresp_valid   = dresp_valid;
        o_dresp_rdata   = dresp_valid ? i_mem_resp_rdata : '0;
        o_mem_req_valid = in_issue;
        o_mem_addr      = in_issue ? {addr_q, 2'b00} : '0;
        o_mem_ren       = in_issue & ~wen_q;
        o_mem_wen       = in_issue & wen_q;
        o_mem_wdata     = in_issue ? wdata_q : '0;
        o_mem_mask      = in_issue ? mask_q : '0;
    end

endmodule
